alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Issue stage that sits directly upstream of the combinational n-bit ALU. It buffers operand/opcode commands in a small FIFO and drives one command at a time onto the ALU A/B/opcode inputs from registers. It then captures the ALU result R into an output register with a valid/ready handshake. Opcode values pass through unchanged; this block never decodes them.

Parameters:
BITS, 4, operand/result width; matches ALU BITS
OPW, 3, opcode width
DEPTH, 4, command FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  command offered
in_ready  out  1  FIFO can accept; = (count < DEPTH)
in_A  in  BITS  operand A
in_B  in  BITS  operand B
in_opcode  in  OPW  opcode
alu_A  out  BITS  registered operand to ALU A
alu_B  out  BITS  registered operand to ALU B
alu_opcode  out  OPW  registered opcode to ALU
alu_R  in  BITS  combinational ALU result
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_R  out  BITS  captured result
out_opcode  out  OPW  opcode that produced out_R
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0 except in_ready=1. State=IDLE, FIFO empty, pointers 0.
- Push: occurs when in_valid && in_ready at an edge. No write-through, and no push when full, even if a pop happens that cycle.
- FIFO: circular buffer with wrap-around pointers. count tracks occupancy and changes by +1, -1, or 0 on simultaneous push+pop.
- FSM states are IDLE, ISSUE and HOLD:
  - IDLE: if count>0, pop the head into alu_A/alu_B/alu_opcode and go to ISSUE. Otherwise stay.
  - ISSUE: one settle cycle. At the next edge, out_R<=alu_R, out_opcode<=alu_opcode, out_valid<=1, go to HOLD.
  - HOLD: out_valid=1; out_R and out_opcode are held stable. On out_valid && out_ready:
    - if count>0, pop the next command into the alu_* regs, out_valid<=0, go to ISSUE;
    - else out_valid<=0, go to IDLE.
- alu_* outputs hold their last command until the next pop; they are never cleared outside reset.
- Latency: a command pushed at edge k into an empty FIFO in IDLE is popped at edge k+1, and out_valid=1 after edge k+2.
- Throughput with out_ready=1: one result per 2 cycles.
- A pop is a FIFO read only; a simultaneous push in the same cycle is allowed and updates count by net 0.
- Reset mid-operation flushes the FIFO and any in-flight or held result. There is no partial completion.
- Width: out_R is exactly BITS; no extension or truncation is done here.

Optional Feature:
ALU_CHAIN_EN
- Defined:
  - Adds input port in_chain (1 bit), stored per FIFO entry.
  - When a popped entry has chain=1, alu_A is loaded with the last captured out_R instead of the entry's A. The last captured out_R is 0 after reset.
  - Enables accumulator-style sequences.
- Undefined:
  - Port absent; alu_A always comes from in_A.
  - Storage is identical to the base design.

Test Plan:
All tests use a bench ALU stub with alu_R = alu_A ^ alu_B.
- Single op: reset; push A=3,B=2,op=5 at edge 0 -> alu_A=3,alu_B=2,alu_opcode=5 after edge 1; out_valid=1,out_R=1,out_opcode=5 after edge 2.
- Fill/backpressure: out_ready=0; offer 6 commands back-to-back from edge 0 -> 5 accepted (edges 0-4), count=4, in_ready=0, 6th held; out_R remains first result.
- Throughput: out_ready=1; push ops (3,2,0),(1,1,1),(7,4,2) -> out_valid pattern 1,0,1,0,1; out_R sequence 1,0,3; out_opcode 0,1,2.
- Wrap-around: push/drain 10 commands A=i,B=0 with random out_ready -> out_R = 0..9 in order, no loss or duplication; count returns to 0.
- Reset mid-op: rst=1 at edge with 3 queued and out_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, alu_A=alu_B=alu_opcode=0; a new push then completes normally.
- ALU_CHAIN_EN: push (3,2,chain=0) then (x,6,chain=1) -> results 1 then 7 (alu_A=1 on second op).

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a combinational ALU: buffers commands in a FIFO, drives them one at a time
// from registers and captures the result behind a valid/ready handshake. Optional macro: ALU_CHAIN_EN.
module alu_cmd_sequencer #(
    parameter int BITS  = 4,
    parameter int OPW   = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS-1:0]          in_A,
    input  logic [BITS-1:0]          in_B,
    input  logic [OPW-1:0]           in_opcode,
`ifdef ALU_CHAIN_EN
    input  logic                     in_chain,
`endif
    output logic [BITS-1:0]          alu_A,
    output logic [BITS-1:0]          alu_B,
    output logic [OPW-1:0]           alu_opcode,
    input  logic [BITS-1:0]          alu_R,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          out_R,
    output logic [OPW-1:0]           out_opcode,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef ALU_CHAIN_EN
    localparam int EW = 2*BITS + OPW + 1;
`else
    localparam int EW = 2*BITS + OPW;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   wdata, head;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push, pop, capture, retire;
    logic [BITS-1:0] head_A, head_B, load_A;
    logic [OPW-1:0]  head_op;
    logic [BITS-1:0] alu_A_reg, alu_B_reg, out_R_reg;
    logic [OPW-1:0]  alu_opcode_reg, out_opcode_reg;
    logic            out_valid_reg;

    assign in_ready = (count_reg < FULL);
    assign push     = in_valid && in_ready;

`ifdef ALU_CHAIN_EN
    assign wdata = {in_chain, in_A, in_B, in_opcode};
`else
    assign wdata = {in_A, in_B, in_opcode};
`endif

    // Entry storage has no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wdata;
    end

    assign head    = mem[rd_ptr_reg];
    assign head_op = head[OPW-1:0];
    assign head_B  = head[OPW +: BITS];
    assign head_A  = head[OPW+BITS +: BITS];

`ifdef ALU_CHAIN_EN
    // Chained entries take A from the most recently captured result.
    assign load_A = head[EW-1] ? out_R_reg : head_A;
`else
    assign load_A = head_A;
`endif

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    retire = 1'b1;
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            alu_A_reg      <= '0;
            alu_B_reg      <= '0;
            alu_opcode_reg <= '0;
            out_R_reg      <= '0;
            out_opcode_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + AW'(1);
                alu_A_reg      <= load_A;
                alu_B_reg      <= head_B;
                alu_opcode_reg <= head_op;
            end
            if (push && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !push)
                count_reg <= count_reg - CW'(1);
            if (capture) begin
                out_R_reg      <= alu_R;
                out_opcode_reg <= alu_opcode_reg;
                out_valid_reg  <= 1'b1;
            end else if (retire) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign alu_A      = alu_A_reg;
    assign alu_B      = alu_B_reg;
    assign alu_opcode = alu_opcode_reg;
    assign out_R      = out_R_reg;
    assign out_opcode = out_opcode_reg;
    assign out_valid  = out_valid_reg;
    assign count      = count_reg;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with an XOR ALU stub; directed timing checks plus
// randomized traffic checked against an in-order command/result model.
module tb_alu_cmd_sequencer;
    localparam int BITS  = 4;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_A, in_B;
    logic [OPW-1:0]  in_opcode;
`ifdef ALU_CHAIN_EN
    logic            in_chain;
`endif
    logic [BITS-1:0] alu_A, alu_B, alu_R;
    logic [OPW-1:0]  alu_opcode;
    logic            out_valid, out_ready;
    logic [BITS-1:0] out_R;
    logic [OPW-1:0]  out_opcode;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    logic [BITS+OPW-1:0] exp_q[$];
    logic [BITS+OPW-1:0] mon_e;
    logic [BITS-1:0]     prev_res = '0;

    always #5 clk = ~clk;

    assign alu_R = alu_A ^ alu_B;

    alu_cmd_sequencer #(.BITS(BITS), .OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode),
`ifdef ALU_CHAIN_EN
        .in_chain(in_chain),
`endif
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_R(alu_R),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_opcode(out_opcode), .count(count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: results come out in command order; a chained command uses the previous result as A.
    task automatic sb_push(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic [OPW-1:0] op, input bit ch);
        logic [BITS-1:0] res;
        res = (ch ? prev_res : a) ^ b;
        prev_res = res;
        exp_q.push_back({res, op});
    endtask

    task automatic set_cmd(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic [OPW-1:0] op, input bit ch);
        in_A = a; in_B = b; in_opcode = op;
`ifdef ALU_CHAIN_EN
        in_chain = ch;
`endif
    endtask

    // Offer a command for exactly one cycle.
    task automatic offer(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [OPW-1:0] op, input bit ch, output bit acc);
        set_cmd(a, b, op, ch);
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc) sb_push(a, b, op, ch);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Offer a command until accepted, optionally randomizing out_ready each cycle.
    task automatic push_wait(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                             input logic [OPW-1:0] op, input bit ch, input bit rand_ready);
        bit done = 1'b0;
        set_cmd(a, b, op, ch);
        for (int n = 0; n < 200 && !done; n++) begin
            in_valid = 1'b1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                sb_push(a, b, op, ch);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && count == 0 && !out_valid) done = 1'b1;
        end
        @(posedge clk); #1;
        check(name, 32'(done), 1);
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected actual R=%0h op=%0h required none", out_R, out_opcode);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_R, out_opcode} !== mon_e) begin
                    errors++;
                    $display("FAIL result actual R=%0h op=%0h required R=%0h op=%0h",
                             out_R, out_opcode, mon_e[BITS+OPW-1:OPW], mon_e[OPW-1:0]);
                end else begin
                    $display("result R=%0h op=%0h ok", out_R, out_opcode);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int acc_n;
        logic [BITS+OPW-1:0] first;
        bit ov_pat [7];
        ov_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_cmd('0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_alu", {alu_A, alu_B, alu_opcode}, 0);
        check("rst_out", {out_R, out_opcode}, 0);
        rst = 1'b0;

        // Single op latency
        out_ready = 1'b1;
        set_cmd(4'd3, 4'd2, 3'd5, 1'b0);
        in_valid = 1'b1;
        sb_push(4'd3, 4'd2, 3'd5, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("single_count", 32'(count), 1);
        @(posedge clk); #1;
        check("single_alu_A", 32'(alu_A), 3);
        check("single_alu_B", 32'(alu_B), 2);
        check("single_alu_op", 32'(alu_opcode), 5);
        check("single_ov_e1", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("single_ov_e2", 32'(out_valid), 1);
        check("single_out_R", 32'(out_R), 1);
        check("single_out_op", 32'(out_opcode), 5);
        drain("single_drain");

        // Fill with backpressure
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            offer(BITS'($urandom), BITS'($urandom), OPW'($urandom), 1'b0, acc);
            if (acc) acc_n++;
        end
        first = exp_q[0];
        check("fill_accepted", 32'(acc_n), 5);
        check("fill_count", 32'(count), 4);
        check("fill_in_ready", 32'(in_ready), 0);
        check("fill_out_valid", 32'(out_valid), 1);
        check("fill_out_R", 32'(out_R), 32'(first[BITS+OPW-1:OPW]));
        drain("fill_drain");

        // Throughput: out_valid alternates with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin set_cmd(4'd3, 4'd2, 3'd0, 1'b0); sb_push(4'd3, 4'd2, 3'd0, 1'b0); end
            if (k == 1) begin set_cmd(4'd1, 4'd1, 3'd1, 1'b0); sb_push(4'd1, 4'd1, 3'd1, 1'b0); end
            if (k == 2) begin set_cmd(4'd7, 4'd4, 3'd2, 1'b0); sb_push(4'd7, 4'd4, 3'd2, 1'b0); end
            in_valid = (k < 3);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("thru_ov_e%0d", k), 32'(out_valid), 32'(ov_pat[k]));
        end
        drain("thru_drain");

        // Wrap-around with random out_ready
        for (int i = 0; i < 10; i++)
            push_wait(BITS'(i), 4'd0, OPW'(i), 1'b0, 1'b1);
        drain("wrap_drain");
        check("wrap_count", 32'(count), 0);

        // Random traffic with idle gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            push_wait(BITS'($urandom), BITS'($urandom), OPW'($urandom), 1'b0, 1'b1);
        end
        drain("rand_drain");

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_wait(BITS'(i + 1), BITS'(i + 8), OPW'(i), 1'b0, 1'b0);
        check("midrst_pre_count", 32'(count), 3);
        check("midrst_pre_ov", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        prev_res = '0;
        rst = 1'b0;
        check("midrst_ov", 32'(out_valid), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_alu", {alu_A, alu_B, alu_opcode}, 0);
        push_wait(4'd5, 4'd6, 3'd3, 1'b0, 1'b0);
        drain("midrst_drain");

`ifdef ALU_CHAIN_EN
        push_wait(4'd3, 4'd2, 3'd1, 1'b0, 1'b0);
        push_wait(4'd9, 4'd6, 3'd2, 1'b1, 1'b0);
        drain("chain_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
